// File: rtl/dp_row_ctrl.sv
// Sequencing controller for one row of dot-product columns.
// It fetches, loads and executes each K-group, then waits out the row pipeline latency.
module dp_row_ctrl #(
    parameter int M        = 4,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_groups,
    input  logic [M-1:0]      col_mask,
    input  logic              w_valid,
    output logic              w_ready,
    output logic              load,
    output logic              execute,
    output logic [M-1:0]      a_select,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] act_addr,
    output logic              psum_clr,
    output logic              psum_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LAT_LAST = 4'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_ngroups;
    logic [CNT_W-1:0]   r_grp;
    logic [3:0]         r_lat;
    logic               r_fin;
    logic               r_w_ready;
    logic               r_load;
    logic               r_execute;
    logic [M-1:0]       r_a_select;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [ADDR_W-1:0]  r_act_addr;
    logic               r_psum_clr;
    logic               r_psum_valid;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_grp_nxt;
    logic               w_job_ok;
    logic               w_accept;
    logic               w_zero;

    // A new job may be taken in IDLE or in the final (done) cycle of DRAIN.
    assign w_grp_nxt = r_grp + CNT_W'(1);
    assign w_job_ok  = (r_state == S_IDLE) || ((r_state == S_DRAIN) && r_fin);
    assign w_accept  = start && w_job_ok && (num_groups != '0);
    assign w_zero    = start && w_job_ok && (num_groups == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ngroups    <= '0;
            r_grp        <= '0;
            r_lat        <= '0;
            r_fin        <= 1'b0;
            r_w_ready    <= 1'b0;
            r_load       <= 1'b0;
            r_execute    <= 1'b0;
            r_a_select   <= '0;
            r_w_addr     <= '0;
            r_act_addr   <= '0;
            r_psum_clr   <= 1'b0;
            r_psum_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_load       <= 1'b0;
            r_execute    <= 1'b0;
            r_psum_clr   <= 1'b0;
            r_psum_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_FETCH;
                        r_ngroups  <= num_groups;
                        r_a_select <= col_mask;
                        r_grp      <= '0;
                        r_w_addr   <= '0;
                        r_act_addr <= '0;
                        r_w_ready  <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (w_zero) begin
                        r_done <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_valid) begin
                        r_state   <= S_LOAD;
                        r_w_ready <= 1'b0;
                        r_load    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_EXEC;
                    r_execute  <= 1'b1;
                    r_psum_clr <= (r_grp == '0);
                end
                S_EXEC: begin
                    r_grp      <= w_grp_nxt;
                    r_w_addr   <= r_w_addr + ADDR_W'(1);
                    r_act_addr <= r_act_addr + ADDR_W'(1);
                    if (w_grp_nxt == r_ngroups) begin
                        r_state <= S_DRAIN;
                        r_lat   <= '0;
                        r_fin   <= 1'b0;
                    end else begin
                        r_state   <= S_FETCH;
                        r_w_ready <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_fin) begin
                        r_fin <= 1'b0;
                        if (w_accept) begin
                            r_state    <= S_FETCH;
                            r_ngroups  <= num_groups;
                            r_a_select <= col_mask;
                            r_grp      <= '0;
                            r_w_addr   <= '0;
                            r_act_addr <= '0;
                            r_w_ready  <= 1'b1;
                        end else begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_a_select <= '0;
                            r_done     <= w_zero;
                        end
                    end else if (r_lat == LAT_LAST) begin
                        // Last wait cycle: the row output is ready next cycle.
                        r_fin        <= 1'b1;
                        r_done       <= 1'b1;
                        r_psum_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_w_ready  <= 1'b0;
                    r_a_select <= '0;
                end
            endcase
        end
    end

    assign w_ready    = r_w_ready;
    assign load       = r_load;
    assign execute    = r_execute;
    assign a_select   = r_a_select;
    assign w_addr     = r_w_addr;
    assign act_addr   = r_act_addr;
    assign psum_clr   = r_psum_clr;
    assign psum_valid = r_psum_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_dp_row_ctrl.sv
// Bench for dp_row_ctrl: each job's event timeline is derived from group count,
// stall lengths and pipeline latency, then every output is compared cycle by cycle.
module tb_dp_row_ctrl;

    localparam int M        = 4;
    localparam int ADDR_W   = 2;
    localparam int CNT_W    = 8;
    localparam int PIPE_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  num_groups;
    logic [M-1:0]      col_mask;
    logic              w_valid;
    logic              w_ready;
    logic              load;
    logic              execute;
    logic [M-1:0]      a_select;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] act_addr;
    logic              psum_clr;
    logic              psum_valid;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;
    int job_id = 0;

    dp_row_ctrl #(.M(M), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .num_groups(num_groups),
        .col_mask(col_mask), .w_valid(w_valid), .w_ready(w_ready), .load(load),
        .execute(execute), .a_select(a_select), .w_addr(w_addr), .act_addr(act_addr),
        .psum_clr(psum_clr), .psum_valid(psum_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the rising edge, then wait to the falling edge to sample.
    task automatic step(input logic s, input logic [CNT_W-1:0] ng, input logic [M-1:0] m,
                        input logic wv, input logic rst);
        @(posedge clk);
        #1;
        start      = s;
        num_groups = ng;
        col_mask   = m;
        w_valid    = wv;
        reset      = rst;
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string pfx, input bit with_addr);
        chk({pfx, " busy"},       32'(busy),       32'd0);
        chk({pfx, " w_ready"},    32'(w_ready),    32'd0);
        chk({pfx, " load"},       32'(load),       32'd0);
        chk({pfx, " execute"},    32'(execute),    32'd0);
        chk({pfx, " psum_clr"},   32'(psum_clr),   32'd0);
        chk({pfx, " psum_valid"}, 32'(psum_valid), 32'd0);
        chk({pfx, " done"},       32'(done),       32'd0);
        chk({pfx, " a_select"},   32'(a_select),   32'd0);
        if (with_addr) begin
            chk({pfx, " w_addr"},   32'(w_addr),   32'd0);
            chk({pfx, " act_addr"}, 32'(act_addr), 32'd0);
        end
    endtask

    // One job of ng groups. stall<0 picks a random stall per fetch. pre: start was
    // already taken on the previous job's done cycle. chain: start the (ng2,m2) job on
    // this job's done cycle. abort_grp>=0: pulse reset during that group's execute cycle.
    task automatic do_job(input int ng, input logic [M-1:0] mask, input int stall,
                          input bit pre, input bit chain, input int ng2,
                          input logic [M-1:0] m2, input int abort_grp);
        int f_lo[$], f_hi[$], ld_c[$], ex_c[$];
        int c, d_cyc, abort_at, n_ex;
        logic wv, sv;
        logic [CNT_W-1:0] ngv;
        logic [M-1:0] mv;
        string pfx;
        c = 1;
        for (int g = 0; g < ng; g++) begin
            int s;
            s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            f_lo.push_back(c);
            f_hi.push_back(c + s);
            ld_c.push_back(c + s + 1);
            ex_c.push_back(c + s + 2);
            c = c + s + 3;
        end
        d_cyc    = ex_c[ng-1] + 1 + PIPE_LAT;
        abort_at = (abort_grp >= 0) ? ex_c[abort_grp] : -1;
        job_id++;
        if (!pre) begin
            step(1'b1, CNT_W'(ng), mask, 1'($urandom), 1'b1);
            chk($sformatf("j%0d c0 busy", job_id), 32'(busy), 32'd0);
            chk($sformatf("j%0d c0 done", job_id), 32'(done), 32'd0);
        end
        for (int cy = 1; cy <= d_cyc; cy++) begin
            logic e_wr, e_ld, e_ex, e_clr, e_fin;
            wv = 1'($urandom);
            e_wr = 1'b0; e_ld = 1'b0; e_ex = 1'b0; n_ex = 0;
            for (int g = 0; g < ng; g++) begin
                if (cy >= f_lo[g] && cy <= f_hi[g]) begin
                    e_wr = 1'b1;
                    wv   = (cy == f_hi[g]);
                end
                if (cy == ld_c[g]) e_ld = 1'b1;
                if (cy == ex_c[g]) e_ex = 1'b1;
                if (ex_c[g] < cy)  n_ex++;
            end
            e_clr = (cy == ex_c[0]);
            e_fin = (cy == d_cyc);
            if (cy == d_cyc) begin
                sv = chain; ngv = CNT_W'(ng2); mv = m2;
            end else begin
                sv  = ($urandom_range(0, 3) == 0);
                ngv = CNT_W'($urandom_range(0, 7));
                mv  = M'($urandom);
            end
            step(sv, ngv, mv, wv, (cy == abort_at) ? 1'b0 : 1'b1);
            pfx = $sformatf("j%0d c%0d", job_id, cy);
            chk({pfx, " busy"},       32'(busy),       32'd1);
            chk({pfx, " a_select"},   32'(a_select),   32'(mask));
            chk({pfx, " w_ready"},    32'(w_ready),    32'(e_wr));
            chk({pfx, " load"},       32'(load),       32'(e_ld));
            chk({pfx, " execute"},    32'(execute),    32'(e_ex));
            chk({pfx, " psum_clr"},   32'(psum_clr),   32'(e_clr));
            chk({pfx, " w_addr"},     32'(w_addr),     32'(n_ex % (1 << ADDR_W)));
            chk({pfx, " act_addr"},   32'(act_addr),   32'(n_ex % (1 << ADDR_W)));
            chk({pfx, " done"},       32'(done),       32'(e_fin));
            chk({pfx, " psum_valid"}, 32'(psum_valid), 32'(e_fin));
            if (cy == abort_at) begin
                for (int k = 0; k < 4; k++) begin
                    step(1'b0, CNT_W'($urandom), M'($urandom), 1'($urandom), 1'b1);
                    chk_quiet($sformatf("j%0d abort+%0d", job_id, k + 1), 1'b1);
                end
                return;
            end
        end
        if (!chain) begin
            step(1'b0, CNT_W'($urandom), M'($urandom), 1'($urandom), 1'b1);
            chk_quiet($sformatf("j%0d after", job_id), 1'b0);
        end
    endtask

    task automatic zero_job(input logic [M-1:0] mask);
        job_id++;
        step(1'b1, '0, mask, 1'($urandom), 1'b1);
        chk($sformatf("j%0d zero c0 done", job_id), 32'(done), 32'd0);
        step(1'b0, CNT_W'($urandom), M'($urandom), 1'($urandom), 1'b1);
        chk($sformatf("j%0d zero c1 done", job_id), 32'(done), 32'd1);
        chk($sformatf("j%0d zero c1 psum_valid", job_id), 32'(psum_valid), 32'd0);
        chk($sformatf("j%0d zero c1 busy", job_id), 32'(busy), 32'd0);
        chk($sformatf("j%0d zero c1 load", job_id), 32'(load), 32'd0);
        chk($sformatf("j%0d zero c1 w_ready", job_id), 32'(w_ready), 32'd0);
        step(1'b0, CNT_W'($urandom), M'($urandom), 1'($urandom), 1'b1);
        chk_quiet($sformatf("j%0d zero c2", job_id), 1'b0);
    endtask

    initial begin
        int ng, ng2;
        logic [M-1:0] mask, m2;
        bit pre, chain;

        reset = 1'b0; start = 1'b0; num_groups = '0; col_mask = '0; w_valid = 1'b0;
        step(1'b1, 8'd3, 4'hF, 1'b1, 1'b0);
        step(1'b1, 8'd3, 4'hF, 1'b1, 1'b0);
        chk_quiet("reset", 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk_quiet("post-reset idle", 1'b1);

        do_job(1, 4'b1011, 0, 1'b0, 1'b0, 0, '0, -1);
        do_job(3, 4'b0110, 2, 1'b0, 1'b0, 0, '0, -1);
        zero_job(4'b1111);
        do_job(6, 4'b1001, 0, 1'b0, 1'b0, 0, '0, -1);
        do_job(4, 4'b1111, 1, 1'b0, 1'b0, 0, '0, 2);
        do_job(2, 4'b0101, 1, 1'b0, 1'b0, 0, '0, -1);
        do_job(2, 4'b1100, 0, 1'b0, 1'b1, 3, 4'b0011, -1);
        do_job(3, 4'b0011, -1, 1'b1, 1'b0, 0, '0, -1);

        pre  = 1'b0;
        ng   = $urandom_range(1, 7);
        mask = M'($urandom);
        for (int j = 0; j < 14; j++) begin
            chain = (j < 13) && ($urandom_range(0, 1) == 1);
            ng2   = $urandom_range(1, 7);
            m2    = M'($urandom);
            do_job(ng, mask, -1, pre, chain, ng2, m2, -1);
            if (chain) begin
                ng = ng2; mask = m2; pre = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) zero_job(M'($urandom));
                ng = $urandom_range(1, 7); mask = M'($urandom); pre = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
